// File: rtl/bus_pkg.sv
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared definitions for the 8-bit arbitrated crypto bus.
//            Byte order and frame field offsets are defined here once so
//            the arbiter and the receive endpoint always agree.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

   localparam int BUS_W         = 8;
   localparam int DEFAULT_ADDRW = 24;

   // Field offsets inside a frame: data byte first, address above it.
   localparam int DATA_LSB = 0;
   localparam int ADDR_LSB = 8;

   // Receiver view of the byte counter / output buffer pair.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_STALL   = 2'd2
   } rx_state_t;

   // Number of bus bytes making up one frame (data byte plus address bytes).
   function automatic int nbytes(input int addrw);
      return (addrw + BUS_W) / BUS_W;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bus_frame_receiver_if.sv
// ============================================================================
// Module   : bus_frame_receiver_if
// Brief    : Byte-stream input and frame output handshake of the bus
//            receive endpoint. The master side drives bytes and consumes
//            frames; the slave side is the receiver itself.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_frame_receiver_if
   import bus_pkg::*;
#(
   parameter int ADDRW = DEFAULT_ADDRW
);

   logic [BUS_W-1:0]       data_in;
   logic                   valid_in;
   logic                   ready_out;
   logic [ADDRW+BUS_W-1:0] frame_out;
   logic                   frame_valid;
   logic                   frame_ready;
   logic                   frame_err;

   modport master (
      output data_in,
      output valid_in,
      output frame_ready,
      input  ready_out,
      input  frame_out,
      input  frame_valid,
      input  frame_err
   );

   modport slave (
      input  data_in,
      input  valid_in,
      input  frame_ready,
      output ready_out,
      output frame_out,
      output frame_valid,
      output frame_err
   );

endinterface

`default_nettype wire

// File: rtl/bus_gap_timer.sv
// ============================================================================
// Module   : bus_gap_timer
// Brief    : Idle-gap watchdog. Counts enabled cycles and raises a single-
//            cycle 'expired' once the count reaches TIMEOUT, then restarts.
//            'clear' wins over 'enable'. TIMEOUT = 0 disables the timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_gap_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   generate
      if (TIMEOUT > 0) begin : g_timer
         localparam int               CNT_W = $clog2(TIMEOUT + 1);
         localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

         logic [CNT_W-1:0] r_count;

         // The expiry cycle is the one where the count sits at the limit.
         assign expired = (r_count == LIMIT);

         // Count enabled cycles; restart on clear or right after expiry.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_count <= '0;
            end else if (clear || expired) begin
               r_count <= '0;
            end else if (enable) begin
               r_count <= r_count + CNT_W'(1);
            end
         end
      end else begin : g_no_timer
         assign expired = 1'b0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/bus_frame_receiver.sv
// ============================================================================
// Module   : bus_frame_receiver
// Brief    : Receive endpoint of the 8-bit arbitrated bus. Reassembles
//            NBYTES-byte sequences (data byte first, address LSB-first)
//            into one frame held in a one-entry valid/ready output buffer.
//            A gap timer drops partial frames that stall mid-sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_frame_receiver
   import bus_pkg::*;
#(
   parameter int ADDRW   = DEFAULT_ADDRW,
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bus_frame_receiver_if.slave  bus
);

   localparam int               NBYTES   = nbytes(ADDRW);
   localparam int               CNT_W    = $clog2(NBYTES);
   localparam int               FRAME_W  = ADDRW + BUS_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_frame_valid;
   logic               w_frame_valid_nxt;
   logic               r_ready;
   logic               w_ready_nxt;
   logic               w_load;
   logic [ADDRW-1:0]   r_shift;
   logic [ADDRW-1:0]   w_shift_nxt;
   logic [FRAME_W-1:0] r_frame_out;
   rx_state_t          w_state;
   logic               w_xfer;
   logic               w_drain;
   logic               w_tmr_en;
   logic               w_tmr_clr;
   logic               w_expired;

   assign w_xfer  = bus.valid_in && r_ready;
   assign w_drain = r_frame_valid && bus.frame_ready;

   // Backpressure cycles are never idle time: only COLLECT without a
   // transfer advances the gap timer.
   assign w_tmr_en  = (w_state == ST_COLLECT) && !w_xfer;
   assign w_tmr_clr = w_xfer || (w_state == ST_IDLE);

   bus_gap_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_gap_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (w_tmr_en),
      .clear   (w_tmr_clr),
      .expired (w_expired)
   );

   // Classify the receiver from the byte counter and the buffer flag.
   always_comb begin
      w_state = ST_COLLECT;
      if (r_cnt == '0) begin
         w_state = ST_IDLE;
      end else if ((r_cnt == CNT_LAST) && r_frame_valid) begin
         w_state = ST_STALL;
      end
   end

   // Next counter, buffer flag and registered byte-accept.
   always_comb begin
      w_cnt_nxt         = r_cnt;
      w_frame_valid_nxt = r_frame_valid;
      w_load            = 1'b0;

      if (w_drain) begin
         w_frame_valid_nxt = 1'b0;
      end

      if (w_expired) begin
         // Abort wins: a byte arriving now starts a fresh frame.
         w_cnt_nxt = w_xfer ? CNT_W'(1) : '0;
      end else if (w_xfer) begin
         if (r_cnt == CNT_LAST) begin
            w_cnt_nxt         = '0;
            w_load            = 1'b1;
            w_frame_valid_nxt = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
      end

      // Drop accept when the next byte would complete a frame into a full
      // buffer; derived from registered state only, so frame_ready has no
      // combinational path to ready_out.
      w_ready_nxt = !((w_cnt_nxt == CNT_LAST) && w_frame_valid_nxt);
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_frame_valid <= 1'b0;
         r_ready       <= 1'b0;
      end else begin
         r_cnt         <= w_cnt_nxt;
         r_frame_valid <= w_frame_valid_nxt;
         r_ready       <= w_ready_nxt;
      end
   end

   // Shift right so byte 0 ends at the bottom once the address is in.
   generate
      if (ADDRW > BUS_W) begin : g_shift_wide
         logic [ADDRW-BUS_W-1:0] w_keep;
         assign w_keep      = w_expired ? '0 : r_shift[ADDRW-1:BUS_W];
         assign w_shift_nxt = {bus.data_in, w_keep};
      end else begin : g_shift_narrow
         assign w_shift_nxt = bus.data_in;
      end
   endgenerate

   // Byte collection and output buffer load; a timeout discards the
   // partial bytes but leaves the buffered frame alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift     <= '0;
         r_frame_out <= '0;
      end else begin
         if (w_xfer) begin
            r_shift <= w_shift_nxt;
         end else if (w_expired) begin
            r_shift <= '0;
         end
         if (w_load) begin
            r_frame_out <= {bus.data_in, r_shift};
         end
      end
   end

   assign bus.ready_out   = r_ready;
   assign bus.frame_valid = r_frame_valid;
   assign bus.frame_out   = r_frame_out;
   assign bus.frame_err   = w_expired;

endmodule

`default_nettype wire

// File: tb/tb_bus_frame_receiver.sv
// ============================================================================
// Module   : tb_bus_frame_receiver
// Brief    : Self-checking bench for bus_frame_receiver. Expected frames are
//            queued as bytes are driven and compared when the consumer
//            handshake completes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_frame_receiver;
   import bus_pkg::*;

   localparam int ADDRW   = 24;
   localparam int TIMEOUT = 16;
   localparam int FRAME_W = ADDRW + BUS_W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_checks     = 0;
   int n_errors     = 0;
   int cyc          = 0;
   int err_pulses   = 0;
   int stall_cycles = 0;
   int start_cyc;
   int c0;
   int c1;
   int err_pos;
   int err_width;

   logic [FRAME_W-1:0] exp_q[$];
   int                 hs_q[$];
   logic [FRAME_W-1:0] f1;
   logic [FRAME_W-1:0] f2;

   bus_frame_receiver_if #(.ADDRW(ADDRW)) bus ();

   bus_frame_receiver #(
      .ADDRW   (ADDRW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Edge counter used for latency checks.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Consumer side: compare each accepted frame against the scoreboard.
   always @(negedge clk) begin
      if (bus.frame_err === 1'b1) err_pulses++;
      if (rst_n && bus.frame_valid && bus.frame_ready) begin
         check_value("sb_frame_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            check_value("frame_out", 64'(bus.frame_out), 64'(exp_q.pop_front()));
            hs_q.push_back(cyc);
         end
      end
   end

   // Called just after a rising edge; returns just after the transfer edge.
   task automatic send_byte(input logic [7:0] b);
      int waited;
      waited = 0;
      bus.data_in  = b;
      bus.valid_in = 1'b1;
      @(negedge clk);
      while (bus.ready_out !== 1'b1 && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      stall_cycles += waited;
      if (waited >= 50) check_value("send_ready_timeout", 64'(waited), 64'd0);
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
   endtask

   task automatic send_frame(input logic [FRAME_W-1:0] f);
      exp_q.push_back(f);
      for (int k = 0; k < FRAME_W / BUS_W; k++) begin
         send_byte(f[8*k +: 8]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.data_in     = '0;
      bus.valid_in    = 1'b0;
      bus.frame_ready = 1'b1;

      // Reset values
      repeat (3) @(negedge clk);
      check_value("rst_ready_out",   64'(bus.ready_out),   64'd0);
      check_value("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
      check_value("rst_frame_out",   64'(bus.frame_out),   64'd0);
      check_value("rst_frame_err",   64'(bus.frame_err),   64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_value("ready_before_first_edge", 64'(bus.ready_out), 64'd0);
      @(negedge clk);
      check_value("ready_after_first_edge", 64'(bus.ready_out), 64'd1);

      // Single frame
      @(posedge clk); #1;
      send_frame(32'hDEADBE42);
      @(negedge clk);
      check_value("single_valid", 64'(bus.frame_valid), 64'd1);
      @(negedge clk);
      check_value("single_valid_one_cycle", 64'(bus.frame_valid), 64'd0);

      // Back-to-back frames
      @(posedge clk); #1;
      stall_cycles = 0;
      hs_q.delete();
      start_cyc = cyc;
      send_frame(32'h3C2B1A09);
      send_frame(32'h88776655);
      repeat (2) @(negedge clk);
      check_value("b2b_stalls", 64'(stall_cycles), 64'd0);
      check_value("b2b_frames", 64'(hs_q.size()), 64'd2);
      c0 = (hs_q.size() > 0) ? hs_q[0] - start_cyc + 1 : -1;
      c1 = (hs_q.size() > 1) ? hs_q[1] - start_cyc + 1 : -1;
      check_value("b2b_frame0_cycle", 64'(c0), 64'd5);
      check_value("b2b_frame1_cycle", 64'(c1), 64'd9);

      // Backpressure
      @(posedge clk); #1;
      bus.frame_ready = 1'b0;
      f1 = 32'h13579BDF;
      f2 = 32'h2468ACE0;
      send_frame(f1);
      exp_q.push_back(f2);
      for (int k = 0; k < 3; k++) send_byte(f2[8*k +: 8]);
      bus.data_in  = f2[31:24];
      bus.valid_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_value("bp_stall_ready", 64'(bus.ready_out),   64'd0);
         check_value("bp_hold_valid",  64'(bus.frame_valid), 64'd1);
         check_value("bp_hold_frame",  64'(bus.frame_out),   64'(f1));
      end
      @(posedge clk); #1;
      bus.frame_ready = 1'b1;
      @(negedge clk);
      check_value("bp_ready_during_drain", 64'(bus.ready_out), 64'd0);
      @(posedge clk); #1;
      bus.frame_ready = 1'b0;
      @(negedge clk);
      check_value("bp_ready_return", 64'(bus.ready_out),   64'd1);
      check_value("bp_buffer_empty", 64'(bus.frame_valid), 64'd0);
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      @(negedge clk);
      check_value("bp_second_valid", 64'(bus.frame_valid), 64'd1);
      check_value("bp_second_frame", 64'(bus.frame_out),   64'(f2));
      @(posedge clk); #1;
      bus.frame_ready = 1'b1;
      @(negedge clk);

      // Timeout of a partial frame
      @(posedge clk); #1;
      send_byte(8'h11);
      send_byte(8'h22);
      err_pos   = -1;
      err_width = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (bus.frame_err === 1'b1) begin
            if (err_pos < 0) err_pos = n;
            err_width++;
         end
      end
      check_value("timeout_err_position", 64'(err_pos),   64'd17);
      check_value("timeout_err_width",    64'(err_width), 64'd1);
      @(posedge clk); #1;
      send_frame(32'h04030201);
      @(negedge clk);

      // Asynchronous reset in the middle of a frame
      @(posedge clk); #1;
      send_byte(8'h0D);
      send_byte(8'hF0);
      #3;
      rst_n = 1'b0;
      #1;
      check_value("midrst_ready_out",   64'(bus.ready_out),   64'd0);
      check_value("midrst_frame_valid", 64'(bus.frame_valid), 64'd0);
      check_value("midrst_frame_out",   64'(bus.frame_out),   64'd0);
      check_value("midrst_frame_err",   64'(bus.frame_err),   64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(32'hCAFEF00D);
      repeat (3) @(negedge clk);

      check_value("sb_drained",       64'(exp_q.size()), 64'd0);
      check_value("total_err_pulses", 64'(err_pulses),   64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bus_frame_receiver.md
# bus_frame_receiver

Receive-side endpoint of the 8-bit arbitrated crypto bus. It accepts the byte stream driven by the bus arbiter (`data_out`/`valid_out`, with `bus_ready` as backpressure) and reassembles each byte sequence into one (ADDRW+8)-bit frame: 8-bit data plus ADDRW-bit address. Completed frames go to the downstream consumer (memory/register interface) through a one-entry valid/ready output buffer. A gap timer discards stalled partial frames.

## Interface
- `ADDRW`, 24, address width in bits; must be a multiple of 8.
- `TIMEOUT`, 16, idle cycles allowed mid-frame before the partial frame is dropped; 0 disables the timer.

- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `data_in`  in  8  bus byte; connects to the arbiter's `data_out`.
- `valid_in`  in  1  byte valid; connects to the arbiter's `valid_out`.
- `ready_out`  out  1  byte accept; drives the arbiter's `bus_ready`.
- `frame_out`  out  ADDRW+8  reassembled frame; `[7:0]` is data, `[ADDRW+7:8]` is address.
- `frame_valid`  out  1  `frame_out` holds a complete frame.
- `frame_ready`  in  1  consumer accepts the frame.
- `frame_err`  out  1  one-cycle pulse when a partial frame is dropped on timeout.

## Operation
- **Frame size:** NBYTES = (ADDRW+8)/8, which is 4 at the default width. Byte k of a frame lands in `frame_out[8k+7:8k]`. Byte 0 (the data byte) arrives first, then the address LSB-first.
- **Byte transfer:** happens on a rising edge where `valid_in && ready_out`.
- **Byte counter `cnt`:** runs 0..NBYTES-1.
  - Increments on each transfer.
  - Wraps to 0 when the last byte transfers.
  - On that same edge, the shift register plus the incoming byte are copied into the output register, which sets `frame_valid`.
- **States** (derived from `cnt` and the output-buffer flag):
  - IDLE: `cnt`=0.
  - COLLECT: 0<`cnt`<NBYTES.
  - STALL: `cnt`=NBYTES-1 and the output buffer is full.
- **`ready_out`** is registered: it is 1 unless the next byte would complete a frame while the output buffer is full and not draining. This gives no combinational path from `frame_ready` to `ready_out`. When the buffer drains in STALL, `ready_out` returns to 1 on the following cycle.
- **Output handshake:**
  - `frame_valid` stays set and `frame_out` stays stable until `frame_valid && frame_ready`.
  - A drain and a new completion on the same edge: the new frame loads and `frame_valid` stays 1.
- **Gap timer:**
  - Counts consecutive cycles with `cnt`≠0 and no transfer; it resets on any transfer or when `cnt`=0.
  - When it reaches TIMEOUT: `cnt` is cleared to 0, the shift register contents are discarded, and `frame_err` pulses for one cycle.
  - The output buffer is unaffected.
- **Timer exemption:** STALL cycles (`ready_out`=0) do not count. Backpressure is never a timeout.
- **Abort priority:** a transfer in the same cycle the timer expires is accepted as byte 0 of a new frame, and `frame_err` still pulses.

## Timing
- **Reset values** (asynchronous, while `rst_n`=0):
  - `ready_out`=0, `frame_valid`=0, `frame_out`=0, `frame_err`=0.
  - `cnt`=0, gap timer=0.
- `ready_out` rises on the first `clk` edge after `rst_n` deasserts.
- **Latency:** `frame_valid` is high in the cycle after the last byte's transfer edge.
- **Throughput:** one byte per cycle sustained, so one frame per NBYTES cycles, as long as the consumer holds `frame_ready`=1.
- **Reset mid-frame:** the partial frame and any buffered frame are lost. `frame_err` is not asserted.
- **`frame_err` timing:** asserted the cycle after the TIMEOUT-th idle cycle; width exactly one cycle.

## Structure
- **Shared package `bus_pkg`:**
  - `BUS_W`=8.
  - Default `ADDRW`.
  - Function `nbytes(addrw)`.
  - Field offsets `DATA_LSB`=0 and `ADDR_LSB`=8.
  - The arbiter and this block both import it so byte order is defined once.
- **Sub-module `bus_gap_timer`:** a counter with `enable`, `clear`, and an `expired` pulse, parameterised by TIMEOUT. It is reusable by the arbiter for grant watchdogs. Everything else stays in this module.

## Test plan
- **Single frame:** reset, then bytes 0x42, 0xBE, 0xAD, 0xDE on consecutive cycles with `frame_ready`=1 → `frame_out`=0xDEADBE42 and `frame_valid` high for one cycle, the cycle after byte 4.
- **Back-to-back frames:** 8 bytes with `valid_in` held 1 and `frame_ready`=1 → two frames, `frame_valid` in cycles 5 and 9, `ready_out` never 0.
- **Backpressure:** `frame_ready`=0 while sending two frames → the first is held stable, `ready_out`=0 before the 2nd frame's last byte (stalling the bus). Raising `frame_ready` for 1 cycle → the first drains, `ready_out` returns the next cycle, and the second frame completes.
- **Timeout:** send 0x11, 0x22, then idle 16 cycles → `frame_err` is a one-cycle pulse and `cnt`=0. The next 4 bytes 0x01..0x04 → `frame_out`=0x04030201.
- **Reset mid-frame:** assert `rst_n`=0 asynchronously after 2 bytes → all outputs are 0 immediately. After release, a full frame of 0xCAFEF00D bytes is received correctly, with no `frame_err`.
